// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: program counter, req/ack fetch sequencing,
// redirect (branch) handling and a sticky memory-timeout error state.
module fetch_pc_unit #(
  parameter int WIDTH    = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0,
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [WIDTH-1:0]   branch_target,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               mem_req,
  output logic [WIDTH-1:0]   pc_out,
  output logic               pc_sel,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic               timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, ERR = 2'd3} state_t;

  localparam logic [WIDTH-1:0] RESET_PC_V = WIDTH'(RESET_PC);
  localparam logic [7:0]       LAST_WAIT  = 8'(MAX_WAIT - 1);

  state_t           state;
  logic [7:0]       wait_cnt;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_target;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] next_pc;

  assign pc_inc = pc_out + WIDTH'(1);

  // The mux select is live in every state but ERR; a same-cycle branch beats a pending one.
  always_comb begin
    pc_sel  = 1'b0;
    next_pc = pc_inc;
    if (!rst && state != ERR) begin
      pc_sel = branch_taken | pend_valid;
      if (branch_taken) begin
        next_pc = branch_target;
      end else if (pend_valid) begin
        next_pc = pend_target;
      end else begin
        next_pc = pc_inc;
      end
    end else begin
      pc_sel  = 1'b0;
      next_pc = pc_inc;
    end
  end

  // Fetch sequencer: state, PC, pending redirect, output registers and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc_out      <= RESET_PC_V;
      mem_req     <= 1'b0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      timeout     <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      wait_cnt    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          state   <= REQ;
          mem_req <= 1'b1;
          if (branch_taken) begin
            pend_valid  <= 1'b1;
            pend_target <= branch_target;
          end
        end
        REQ: begin
          if (mem_ack) begin
            wait_cnt <= 8'd0;
            if (pc_sel) begin
              // The returned word belongs to the abandoned path.
              pc_out      <= next_pc;
              pend_valid  <= 1'b0;
              instr_valid <= 1'b0;
            end else begin
              instr_out   <= instr_in;
              instr_valid <= 1'b1;
              if (stall) begin
                state   <= HOLD;
                mem_req <= 1'b0;
              end else begin
                pc_out <= pc_inc;
              end
            end
          end else begin
            instr_valid <= 1'b0;
            wait_cnt    <= wait_cnt + 8'd1;
            if (branch_taken) begin
              pend_valid  <= 1'b1;
              pend_target <= branch_target;
            end
            if (wait_cnt == LAST_WAIT) begin
              state   <= ERR;
              timeout <= 1'b1;
              mem_req <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (branch_taken || !stall) begin
            // A redirect here discards the held word even while stalled.
            pc_out      <= next_pc;
            pend_valid  <= 1'b0;
            instr_valid <= 1'b0;
            state       <= REQ;
            mem_req     <= 1'b1;
          end
        end
        ERR: begin
          mem_req <= 1'b0;
          timeout <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit with a simple memory that
// returns 16'hA000 + address.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        mem_ack;
  logic [15:0] instr_in;
  logic        mem_req;
  logic [7:0]  pc_out;
  logic        pc_sel;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign instr_in = {8'hA0, pc_out};

  fetch_pc_unit #(.WIDTH(8), .INSTR_W(16), .RESET_PC(0), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .mem_ack(mem_ack), .instr_in(instr_in),
    .mem_req(mem_req), .pc_out(pc_out), .pc_sel(pc_sel), .instr_out(instr_out),
    .instr_valid(instr_valid), .timeout(timeout)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string tag, input logic [7:0] pc, input logic [15:0] ins,
                             input logic vld, input logic req);
    check({tag, ".pc"}, {8'h00, pc_out}, {8'h00, pc});
    check({tag, ".instr"}, instr_out, ins);
    check({tag, ".valid"}, {15'd0, instr_valid}, {15'd0, vld});
    check({tag, ".req"}, {15'd0, mem_req}, {15'd0, req});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_fetch("reset", 8'h00, 16'h0000, 1'b0, 1'b0);
    check("reset.timeout", {15'd0, timeout}, 16'd0);
    check("reset.pc_sel", {15'd0, pc_sel}, 16'd0);

    // Sequential fetch, ack tied high
    rst = 1'b0; mem_ack = 1'b1;
    step(); check_fetch("idle2req", 8'h00, 16'h0000, 1'b0, 1'b1);
    step(); check_fetch("seq1", 8'h01, 16'hA000, 1'b1, 1'b1);
    step(); check_fetch("seq2", 8'h02, 16'hA001, 1'b1, 1'b1);
    step(); check_fetch("seq3", 8'h03, 16'hA002, 1'b1, 1'b1);

    // Redirect to FF, then wrap to 00
    branch_taken = 1'b1; branch_target = 8'hFF; #1;
    check("br_ff.pc_sel", {15'd0, pc_sel}, 16'd1);
    step(); branch_taken = 1'b0; #1;
    check_fetch("squash_ff", 8'hFF, 16'hA002, 1'b0, 1'b1);
    check("squash_ff.pc_sel", {15'd0, pc_sel}, 16'd0);
    step(); check_fetch("wrap", 8'h00, 16'hA0FF, 1'b1, 1'b1);
    check("wrap.pc_sel", {15'd0, pc_sel}, 16'd0);

    // Branch coincident with ack at pc 05
    repeat (5) step();
    check("at05.pc", {8'h00, pc_out}, 16'h0005);
    branch_taken = 1'b1; branch_target = 8'h40; #1;
    check("br40.pc_sel", {15'd0, pc_sel}, 16'd1);
    step(); branch_taken = 1'b0;
    check_fetch("squash40", 8'h40, 16'hA004, 1'b0, 1'b1);
    step(); check_fetch("fetch40", 8'h41, 16'hA040, 1'b1, 1'b1);

    // Branch while waiting for ack is held pending and squashes the next ack
    mem_ack = 1'b0; branch_taken = 1'b1; branch_target = 8'h20;
    step(); branch_taken = 1'b0; mem_ack = 1'b1; #1;
    check_fetch("pend_wait", 8'h41, 16'hA040, 1'b0, 1'b1);
    check("pend.pc_sel", {15'd0, pc_sel}, 16'd1);
    step(); check_fetch("pend_squash", 8'h20, 16'hA040, 1'b0, 1'b1);
    check("pend_clr.pc_sel", {15'd0, pc_sel}, 16'd0);
    step(); check_fetch("fetch20", 8'h21, 16'hA020, 1'b1, 1'b1);

    // Stall at pc 10 for three cycles
    branch_taken = 1'b1; branch_target = 8'h10;
    step(); branch_taken = 1'b0; stall = 1'b1;
    check_fetch("to10", 8'h10, 16'hA020, 1'b0, 1'b1);
    step(); check_fetch("hold1", 8'h10, 16'hA010, 1'b1, 1'b0);
    step(); check_fetch("hold2", 8'h10, 16'hA010, 1'b1, 1'b0);
    step(); check_fetch("hold3", 8'h10, 16'hA010, 1'b1, 1'b0);
    stall = 1'b0;
    step(); check_fetch("release", 8'h11, 16'hA010, 1'b0, 1'b1);
    step(); check_fetch("fetch11", 8'h12, 16'hA011, 1'b1, 1'b1);

    // Branch during HOLD drops the held word
    stall = 1'b1;
    step(); check_fetch("hold12", 8'h12, 16'hA012, 1'b1, 1'b0);
    branch_taken = 1'b1; branch_target = 8'h80;
    step(); branch_taken = 1'b0; stall = 1'b0;
    check_fetch("hold_br", 8'h80, 16'hA012, 1'b0, 1'b1);
    step(); check_fetch("fetch80", 8'h81, 16'hA080, 1'b1, 1'b1);

    // Timeout after 15 cycles without ack
    mem_ack = 1'b0;
    repeat (14) step();
    check("wait14.timeout", {15'd0, timeout}, 16'd0);
    check("wait14.req", {15'd0, mem_req}, 16'd1);
    step();
    check_fetch("timeout", 8'h81, 16'hA080, 1'b0, 1'b0);
    check("timeout.flag", {15'd0, timeout}, 16'd1);
    mem_ack = 1'b1; branch_taken = 1'b1; branch_target = 8'h33; #1;
    check("err.pc_sel", {15'd0, pc_sel}, 16'd0);
    repeat (2) step();
    check_fetch("err_frozen", 8'h81, 16'hA080, 1'b0, 1'b0);
    check("err.flag", {15'd0, timeout}, 16'd1);
    branch_taken = 1'b0;
    rst = 1'b1; #1;
    check_fetch("err_rst", 8'h00, 16'h0000, 1'b0, 1'b0);
    check("err_rst.timeout", {15'd0, timeout}, 16'd0);

    // Asynchronous reset while waiting for ack
    step(); rst = 1'b0; mem_ack = 1'b1;
    step(); step(); step();
    check_fetch("pre_rst", 8'h02, 16'hA001, 1'b1, 1'b1);
    mem_ack = 1'b0;
    step(); step();
    #2; rst = 1'b1; #1;
    check_fetch("async_rst", 8'h00, 16'h0000, 1'b0, 1'b0);
    check("async_rst.timeout", {15'd0, timeout}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
